md_sequencer: RTL and testbench

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer_if.sv | 34 +++
 rtl/md_sequencer.sv | 153 +++++++++++++++
 tb/tb_md_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : md_sequencer_if
// Brief    : Issue/control and result bundle between the E-stage and the
//            multiply/divide sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface md_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        wr_hi;
    logic        wr_lo;
    logic        cancel;
    logic        busy;
    logic [3:0]  tnew;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, wr_hi, wr_lo, cancel,
        input  busy, tnew, md_stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, wr_hi, wr_lo, cancel,
        output busy, tnew, md_stall, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/md_sequencer.sv
//------------------------------------------------------------------------------
// Module   : md_sequencer
// Brief    : Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic     clk,
    input  wire logic     reset,
    md_sequencer_if.slave md
);
    localparam logic [0:0] c_IDLE      = 1'b0;
    localparam logic [0:0] c_RUN       = 1'b1;
    localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYCLES);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [3:0]  r_count;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_issue;
    logic        w_busy;
    logic        w_accept;
    logic        w_commit;
    logic        w_mt_hi;
    logic        w_mt_lo;

    assign w_issue = md.start & ~md.cancel;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_issue) w_state_nxt = c_RUN;
            c_RUN:   if (r_count == 4'd1) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs and control strobes; mthi/mtlo lose to a same-cycle issue
    always_comb begin
        w_busy      = (r_state == c_RUN);
        w_accept    = (r_state == c_IDLE) & w_issue;
        w_commit    = w_busy & (r_count == 4'd1);
        w_mt_hi     = (r_state == c_IDLE) & ~w_issue & ~md.cancel & md.wr_hi;
        w_mt_lo     = (r_state == c_IDLE) & ~w_issue & ~md.cancel & md.wr_lo;
        md.busy     = w_busy;
        md.tnew     = r_count;
        md.md_stall = w_busy | w_issue;
        md.hi       = r_hi;
        md.lo       = r_lo;
    end

    // Arithmetic on the latched operands
    logic        w_signed;
    logic        w_is_div;
    logic        w_div_zero;
    logic [63:0] w_prod;
    logic [63:0] w_mul_res;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_signed   = ~r_op[0];
    assign w_is_div   = (r_op[2:1] == 2'b01);
    assign w_div_zero = (r_b == 32'd0);

    always_comb begin
        if (w_signed) begin
            w_prod = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
        end else begin
            w_prod = {32'd0, r_a} * {32'd0, r_b};
        end
        w_mul_res = w_prod;
        if (r_op[2]) begin
            w_mul_res = r_op[1] ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
        end
    end

    // Sign-magnitude division keeps 0x80000000 / -1 well defined
    always_comb begin
        w_a_neg  = w_signed & r_a[31];
        w_b_neg  = w_signed & r_b[31];
        w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
        w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
        w_b_safe = w_div_zero ? 32'd1 : w_b_mag;
        w_q_mag  = w_a_mag / w_b_safe;
        w_r_mag  = w_a_mag % w_b_safe;
        w_quo    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 4'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op    <= md.op;
                r_a     <= md.rs_val;
                r_b     <= md.rt_val;
                r_count <= (md.op[2:1] == 2'b01) ? c_DIV_LOAD : c_MULT_LOAD;
            end else if (w_busy) begin
                r_count <= r_count - 4'd1;
            end

            if (w_commit) begin
                if (w_is_div) begin
                    if (!w_div_zero) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end else begin
                    r_hi <= w_mul_res[63:32];
                    r_lo <= w_mul_res[31:0];
                end
            end

            if (w_mt_hi) r_hi <= md.rs_val;
            if (w_mt_lo) r_lo <= md.rs_val;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_md_sequencer
// Brief    : Directed self-checking bench for md_sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_md_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;

    md_sequencer_if u_if ();

    md_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        u_if.start  = 1'b0;
        u_if.wr_hi  = 1'b0;
        u_if.wr_lo  = 1'b0;
        u_if.cancel = 1'b0;
    endtask

    // Returns at the negedge after the accepting edge (first RUN cycle)
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wr);
        @(negedge clk);
        u_if.start  = 1'b1;
        u_if.op     = op;
        u_if.rs_val = a;
        u_if.rt_val = b;
        u_if.wr_hi  = wr;
        u_if.wr_lo  = wr;
        #1 check("stall_on_issue", u_if.md_stall, 1);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] v, input logic canc);
        @(negedge clk);
        u_if.wr_hi  = h;
        u_if.wr_lo  = l;
        u_if.rs_val = v;
        u_if.cancel = canc;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (u_if.busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_bounded", {63'd0, u_if.busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        u_if.op     = 3'd0;
        u_if.rs_val = 32'd0;
        u_if.rt_val = 32'd0;
        clear_inputs();
        #3;
        check("rst_busy", u_if.busy, 0);
        check("rst_tnew", u_if.tnew, 0);
        check("rst_hilo", {u_if.hi, u_if.lo}, 64'd0);
        check("rst_stall", u_if.md_stall, 0);
        @(negedge clk);
        reset = 1'b0;

        // mult 3 * -2, with op/operand changes during RUN
        issue(3'd0, 32'd3, 32'hFFFF_FFFE, 1'b0);
        u_if.op     = 3'd2;
        u_if.rs_val = 32'd0;
        check("mult_busy", u_if.busy, 1);
        check("mult_tnew5", u_if.tnew, 5);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("mult_tnew_seq", u_if.tnew, 64'(5 - i));
        end
        check("mult_idle", u_if.busy, 0);
        check("mult_hilo", {u_if.hi, u_if.lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // multu with simultaneous mthi/mtlo: writes ignored
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done(cyc);
        check("multu_cycles", cyc, 5);
        check("multu_hilo", {u_if.hi, u_if.lo}, 64'h0000_0001_FFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(cyc);
        check("div_cycles", cyc, 10);
        check("div_hilo", {u_if.hi, u_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(3'd3, 32'd7, 32'd2, 1'b0);
        wait_done(cyc);
        check("divu_hilo", {u_if.hi, u_if.lo}, {32'd1, 32'd3});

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(cyc);
        check("div_ovf_hilo", {u_if.hi, u_if.lo}, {32'd0, 32'h8000_0000});

        // accumulate sequence
        mt(1'b1, 1'b0, 32'd0, 1'b0);
        mt(1'b0, 1'b1, 32'd5, 1'b0);
        check("mt_hilo", {u_if.hi, u_if.lo}, {32'd0, 32'd5});
        issue(3'd4, 32'd2, 32'd3, 1'b0);
        wait_done(cyc);
        check("madd_hilo", {u_if.hi, u_if.lo}, {32'd0, 32'd11});
        issue(3'd7, 32'd4, 32'd4, 1'b0);
        wait_done(cyc);
        check("msubu_hilo", {u_if.hi, u_if.lo}, 64'hFFFF_FFFF_FFFF_FFFB);

        // divide by zero, second start and mthi during RUN ignored
        mt(1'b1, 1'b0, 32'hAAAA_0000, 1'b0);
        mt(1'b0, 1'b1, 32'h0000_5555, 1'b0);
        issue(3'd3, 32'h1234, 32'd0, 1'b0);
        check("dz_tnew10", u_if.tnew, 10);
        @(negedge clk);
        @(negedge clk);
        u_if.start  = 1'b1;
        u_if.op     = 3'd0;
        u_if.rs_val = 32'd9;
        u_if.rt_val = 32'd9;
        u_if.wr_hi  = 1'b1;
        @(negedge clk);
        clear_inputs();
        check("dz_no_reload", u_if.tnew, 7);
        wait_done(cyc);
        check("dz_rest_cycles", cyc, 7);
        check("dz_hilo", {u_if.hi, u_if.lo}, 64'hAAAA_0000_0000_5555);
        @(negedge clk);
        check("dz_no_rerun", u_if.busy, 0);

        // cancel suppresses start and mtlo
        @(negedge clk);
        u_if.start  = 1'b1;
        u_if.cancel = 1'b1;
        u_if.op     = 3'd0;
        #1 check("cancel_stall", u_if.md_stall, 0);
        @(negedge clk);
        clear_inputs();
        check("cancel_busy", u_if.busy, 0);
        check("cancel_tnew", u_if.tnew, 0);
        mt(1'b0, 1'b1, 32'h77, 1'b1);
        check("cancel_mtlo", u_if.lo, 32'h5555);

        // reset during RUN
        mt(1'b1, 1'b1, 32'h11, 1'b0);
        check("mt_both", {u_if.hi, u_if.lo}, {32'h11, 32'h11});
        issue(3'd0, 32'd3, 32'd3, 1'b0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_busy", u_if.busy, 0);
        check("arst_tnew", u_if.tnew, 0);
        check("arst_hilo", {u_if.hi, u_if.lo}, 64'd0);
        u_if.start = 1'b1;
        #1 check("arst_stall", u_if.md_stall, 1);
        u_if.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("arst_no_commit_busy", u_if.busy, 0);
        check("arst_no_commit_hilo", {u_if.hi, u_if.lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
